// File: rtl/fetch_stall_controller.sv
// Fetch stage: owns the fetch PC and the IF/ID register, runs the req/ack
// instruction-memory handshake, absorbs load-use stalls and drains flushed requests.
module fetch_stall_controller #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int INSTR_WIDTH    = 32,
  parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_INCREMENT   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      inPCWrite,
  input  logic                      inIfIdWrite,
  input  logic                      inFlush,
  input  logic [BUS_DATA_WIDTH-1:0] inBranchTarget,
  output logic                      outImemReq,
  output logic [BUS_DATA_WIDTH-1:0] outImemAddr,
  input  logic                      inImemAck,
  input  logic [INSTR_WIDTH-1:0]    inImemData,
  output logic [BUS_DATA_WIDTH-1:0] outPC,
  output logic [INSTR_WIDTH-1:0]    outInstruction,
  output logic                      outValid,
  output logic [15:0]               outStallCount
);

  typedef enum logic [1:0] {ST_REQ, ST_HOLD, ST_DRAIN} state_t;

  state_t                    state_reg, state_next;
  logic                      running_reg;
  logic [BUS_DATA_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [BUS_DATA_WIDTH-1:0] drain_addr_reg, drain_addr_next;
  logic [BUS_DATA_WIDTH-1:0] buf_pc_reg, buf_pc_next;
  logic [INSTR_WIDTH-1:0]    buf_instr_reg, buf_instr_next;
  logic [BUS_DATA_WIDTH-1:0] if_pc_reg, if_pc_next;
  logic [INSTR_WIDTH-1:0]    if_instr_reg, if_instr_next;
  logic                      if_valid_reg, if_valid_next;
  logic [15:0]               stall_count_reg, stall_count_next;

  logic                      stall;
  logic [BUS_DATA_WIDTH-1:0] pc_inc;

  assign stall  = !inPCWrite || !inIfIdWrite;
  assign pc_inc = fetch_pc_reg + BUS_DATA_WIDTH'(PC_INCREMENT);

  // running_reg keeps the request low during reset and rises one edge after release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_REQ;
      running_reg     <= 1'b0;
      fetch_pc_reg    <= RESET_PC;
      drain_addr_reg  <= '0;
      buf_pc_reg      <= '0;
      buf_instr_reg   <= '0;
      if_pc_reg       <= '0;
      if_instr_reg    <= '0;
      if_valid_reg    <= 1'b0;
      stall_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      running_reg     <= 1'b1;
      fetch_pc_reg    <= fetch_pc_next;
      drain_addr_reg  <= drain_addr_next;
      buf_pc_reg      <= buf_pc_next;
      buf_instr_reg   <= buf_instr_next;
      if_pc_reg       <= if_pc_next;
      if_instr_reg    <= if_instr_next;
      if_valid_reg    <= if_valid_next;
      stall_count_reg <= stall_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    drain_addr_next  = drain_addr_reg;
    buf_pc_next      = buf_pc_reg;
    buf_instr_next   = buf_instr_reg;
    if_pc_next       = if_pc_reg;
    if_instr_next    = if_instr_reg;
    if_valid_next    = if_valid_reg;
    stall_count_next = stall_count_reg;

    if (stall && !inFlush && stall_count_reg != 16'hFFFF)
      stall_count_next = stall_count_reg + 16'd1;

    if (running_reg) begin
      case (state_reg)
        ST_REQ: begin
          if (inFlush) begin
            if_valid_next = 1'b0;
            if_instr_next = '0;
            fetch_pc_next = inBranchTarget;
            if (!inImemAck) begin
              // The outstanding request must still complete at its old address.
              drain_addr_next = fetch_pc_reg;
              state_next      = ST_DRAIN;
            end
          end else if (inImemAck) begin
            if (!stall) begin
              if_pc_next    = fetch_pc_reg;
              if_instr_next = inImemData;
              if_valid_next = 1'b1;
              fetch_pc_next = pc_inc;
            end else begin
              buf_pc_next    = fetch_pc_reg;
              buf_instr_next = inImemData;
              state_next     = ST_HOLD;
            end
          end else if (!stall) begin
            if_valid_next = 1'b0;
          end
        end
        ST_HOLD: begin
          if (inFlush) begin
            if_valid_next = 1'b0;
            if_instr_next = '0;
            fetch_pc_next = inBranchTarget;
            state_next    = ST_REQ;
          end else if (!stall) begin
            if_pc_next    = buf_pc_reg;
            if_instr_next = buf_instr_reg;
            if_valid_next = 1'b1;
            fetch_pc_next = pc_inc;
            state_next    = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (inFlush) begin
            if_valid_next = 1'b0;
            if_instr_next = '0;
            fetch_pc_next = inBranchTarget;
          end
          if (inImemAck)
            state_next = ST_REQ;
        end
        default: state_next = ST_REQ;
      endcase
    end
  end

  assign outImemReq     = running_reg && (state_reg != ST_HOLD);
  assign outImemAddr    = (state_reg == ST_DRAIN) ? drain_addr_reg : fetch_pc_reg;
  assign outPC          = if_pc_reg;
  assign outInstruction = if_instr_reg;
  assign outValid       = if_valid_reg;
  assign outStallCount  = stall_count_reg;

endmodule
